// File: rtl/bsg_mux2_gatestack_feeder_pkg.sv
// Shared constants for the gatestack mux feeder: FIFO depth and occupancy encodings.
package bsg_mux2_gatestack_feeder_pkg;

  localparam int unsigned fifo_depth_lp = 2;
  localparam logic [1:0]  count_empty_lp = 2'd0;
  localparam logic [1:0]  count_full_lp  = 2'd2;

endpackage

// File: rtl/bsg_expand_bitmask.sv
// Expands a coarse enable vector into a per-bit mask: bit j follows en_i[j / gran_p].
module bsg_expand_bitmask #(
  parameter int width_p = 32,
  parameter int gran_p  = 8,
  localparam int en_width_lp = width_p / gran_p
) (
  input  logic [en_width_lp-1:0] en_i,
  output logic [width_p-1:0]     mask_o
);

  if (width_p % gran_p != 0) begin : g_bad_gran
    $error("bsg_expand_bitmask: width_p must be a multiple of gran_p");
  end

  for (genvar j = 0; j < width_p; j++) begin : g_bit
    assign mask_o[j] = en_i[j / gran_p];
  end

endmodule

// File: rtl/bsg_mux2_gatestack_feeder.sv
// Registered 2-entry operand FIFO feeding a per-bit 2:1 mux (o = sel ? b : a).
module bsg_mux2_gatestack_feeder
  import bsg_mux2_gatestack_feeder_pkg::*;
#(
  parameter int width_p = 32,
  parameter int gran_p  = 8,
  localparam int en_width_lp = width_p / gran_p
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   v_i,
  output logic                   ready_o,
  input  logic [width_p-1:0]     base_i,
  input  logic [width_p-1:0]     data_i,
  input  logic [en_width_lp-1:0] en_i,
  output logic                   v_o,
  output logic [width_p-1:0]     a_o,
  output logic [width_p-1:0]     b_o,
  output logic [width_p-1:0]     sel_o,
  input  logic                   yumi_i,
  output logic [1:0]             count_o
);

  // Handshakes: a request transfers on v_i & ready_o, operands are consumed on
  // yumi_i & v_o. ready_o and v_o depend only on registered state.

  logic [width_p-1:0] mask_in;

  bsg_expand_bitmask #(
    .width_p(width_p),
    .gran_p (gran_p)
  ) expand (
    .en_i  (en_i),
    .mask_o(mask_in)
  );

  logic [fifo_depth_lp-1:0][width_p-1:0] base_q, base_d;
  logic [fifo_depth_lp-1:0][width_p-1:0] data_q, data_d;
  logic [fifo_depth_lp-1:0][width_p-1:0] mask_q, mask_d;
  logic       wp_q, wp_d;
  logic       rp_q, rp_d;
  logic [1:0] count_q, count_d;
  logic       enq, deq;

  assign ready_o = (count_q != count_full_lp);
  assign v_o     = (count_q != count_empty_lp);
  assign count_o = count_q;
  assign a_o     = base_q[rp_q];
  assign b_o     = data_q[rp_q];
  assign sel_o   = mask_q[rp_q];

  always_comb begin
    base_d  = base_q;
    data_d  = data_q;
    mask_d  = mask_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    enq     = v_i & ready_o;
    deq     = yumi_i & v_o;
    if (enq) begin
      base_d[wp_q] = base_i;
      data_d[wp_q] = data_i;
      mask_d[wp_q] = mask_in;
      wp_d         = ~wp_q;
    end
    if (deq) begin
      rp_d = ~rp_q;
    end
    count_d = count_q + 2'(enq) - 2'(deq);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      base_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      wp_q    <= 1'b0;
      rp_q    <= 1'b0;
      count_q <= '0;
    end else begin
      base_q  <= base_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

`ifndef SYNTHESIS
  // Consuming with nothing valid is ignored by the datapath but flagged here.
  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!(yumi_i && !v_o))
        else $warning("bsg_mux2_gatestack_feeder: yumi_i asserted while v_o=0");
    end
  end
`endif

endmodule

// File: tb/tb_bsg_mux2_gatestack_feeder.sv
// Directed + random bench for the gatestack feeder against a queue-based reference model.
module tb_bsg_mux2_gatestack_feeder;

  localparam int W  = 32;
  localparam int G  = 8;
  localparam int EW = W / G;

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic          v_i, yumi_i;
  logic          ready_o, v_o;
  logic [W-1:0]  base_i, data_i, a_o, b_o, sel_o;
  logic [EW-1:0] en_i;
  logic [1:0]    count_o;

  int checks   = 0;
  int failures = 0;

  // Each model entry is {base, data, mask}.
  logic [3*W-1:0] exp_q[$];

  bsg_mux2_gatestack_feeder #(.width_p(W), .gran_p(G)) dut (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .v_i      (v_i),
    .ready_o  (ready_o),
    .base_i   (base_i),
    .data_i   (data_i),
    .en_i     (en_i),
    .v_o      (v_o),
    .a_o      (a_o),
    .b_o      (b_o),
    .sel_o    (sel_o),
    .yumi_i   (yumi_i),
    .count_o  (count_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [W-1:0] expand_ref(input logic [EW-1:0] en);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < EW; k++) begin
      if (en[k]) r = r | ({{(W-G){1'b0}}, {G{1'b1}}} << (G * k));
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // Compare all DUT outputs with the model's view of the FIFO.
  task automatic check_model(input string tag);
    logic [W-1:0] eb, ed, em;
    check({tag, ".count"}, W'(count_o), W'(exp_q.size()));
    check({tag, ".v_o"}, W'(v_o), W'(exp_q.size() != 0));
    check({tag, ".ready_o"}, W'(ready_o), W'(exp_q.size() < 2));
    if (exp_q.size() != 0) begin
      {eb, ed, em} = exp_q[0];
      check({tag, ".a_o"}, a_o, eb);
      check({tag, ".b_o"}, b_o, ed);
      check({tag, ".sel_o"}, sel_o, em);
      check({tag, ".mux"}, (sel_o & b_o) | (~sel_o & a_o), (em & ed) | (~em & eb));
    end
  endtask

  // One cycle: inputs driven after posedge, outputs checked at negedge, model advanced at posedge.
  task automatic step(input string tag, input logic v, input logic y,
                      input logic [W-1:0] b, input logic [W-1:0] d, input logic [EW-1:0] e);
    bit do_enq, do_deq;
    v_i = v; yumi_i = y; base_i = b; data_i = d; en_i = e;
    @(negedge clk_i);
    check_model(tag);
    do_enq = v && (exp_q.size() < 2);
    do_deq = y && (exp_q.size() != 0);
    @(posedge clk_i);
    if (do_deq) void'(exp_q.pop_front());
    if (do_enq) exp_q.push_back({b, d, expand_ref(e)});
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".v_o"}, W'(v_o), '0);
    check({tag, ".count"}, W'(count_o), '0);
    check({tag, ".ready_o"}, W'(ready_o), W'(1));
    check({tag, ".a_o"}, a_o, '0);
    check({tag, ".b_o"}, b_o, '0);
    check({tag, ".sel_o"}, sel_o, '0);
  endtask

  initial begin
    logic [W-1:0] r1, r2, r3;
    reset_n_i = 1'b0; v_i = 0; yumi_i = 0; base_i = '0; data_i = '0; en_i = '0;
    #1;
    check_reset_state("reset_hold");
    repeat (2) @(posedge clk_i);
    @(negedge clk_i) reset_n_i = 1'b1;
    @(posedge clk_i); #1;

    // Byte-enable expansion example.
    step("be_enq", 1, 0, 32'h11223344, 32'hAABBCCDD, 4'b0101);
    check("be_sel", sel_o, 32'h00FF00FF);
    check("be_mux", (sel_o & b_o) | (~sel_o & a_o), 32'h11BB33DD);
    step("be_hold", 0, 0, '0, '0, '0);
    step("be_deq", 0, 1, '0, '0, '0);
    step("be_empty", 0, 0, '0, '0, '0);

    // Backpressure: third request held until space opens.
    r1 = $urandom; r2 = $urandom; r3 = $urandom;
    step("bp_1", 1, 0, r1, ~r1, 4'b0011);
    step("bp_2", 1, 0, r2, ~r2, 4'b1100);
    step("bp_3a", 1, 0, r3, ~r3, 4'b1111);
    step("bp_3b", 1, 0, r3, ~r3, 4'b1111);
    check("bp_count", W'(count_o), W'(2));
    check("bp_ready", W'(ready_o), '0);
    check("bp_front", a_o, r1);
    // Full with yumi: no enqueue this cycle, request 3 accepted next.
    step("fy_pop", 1, 1, r3, ~r3, 4'b1111);
    check("fy_front", a_o, r2);
    step("fy_acc", 1, 0, r3, ~r3, 4'b1111);
    step("fy_d1", 0, 1, '0, '0, '0);
    step("fy_d2", 0, 1, '0, '0, '0);
    step("fy_idle", 0, 0, '0, '0, '0);

    // Streaming with incrementing data over 64 requests.
    step("st_prime", 1, 0, $urandom, W'(0), 4'($urandom_range(0, 15)));
    for (int i = 1; i < 64; i++) begin
      step("st", 1, 1, $urandom, W'(i), 4'($urandom_range(0, 15)));
      check("st_count", W'(count_o), W'(1));
    end
    step("st_drain", 0, 1, '0, '0, '0);
    step("st_empty", 0, 0, '0, '0, '0);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      step("rnd", 1'($urandom_range(0, 1)),
           (exp_q.size() != 0) ? 1'($urandom_range(0, 1)) : 1'b0,
           $urandom, $urandom, 4'($urandom_range(0, 15)));
    end
    while (exp_q.size() != 0) step("rnd_drain", 0, 1, '0, '0, '0);

    // Protocol error: consume while empty leaves state unchanged.
    step("perr", 0, 1, '0, '0, '0);
    step("perr_after", 0, 0, '0, '0, '0);

    // Mid-stream reset with a full FIFO.
    step("mr_1", 1, 0, $urandom, $urandom, 4'($urandom_range(0, 15)));
    step("mr_2", 1, 0, $urandom, $urandom, 4'($urandom_range(0, 15)));
    v_i = 0; yumi_i = 0;
    check("mr_full", W'(count_o), W'(2));
    reset_n_i = 1'b0;
    #1;
    check_reset_state("mr_reset");
    exp_q.delete();
    @(negedge clk_i) reset_n_i = 1'b1;
    @(posedge clk_i); #1;
    step("mr_first", 1, 0, 32'hCAFEF00D, 32'h0BADBEEF, 4'b1001);
    check("mr_lat1_v", W'(v_o), W'(1));
    check("mr_lat1_sel", sel_o, 32'hFF0000FF);
    step("mr_deq", 0, 1, '0, '0, '0);
    step("mr_end", 0, 0, '0, '0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bsg_mux2_gatestack_feeder.md
Name: bsg_mux2_gatestack_feeder

Overview:
- Upstream operand stage for the per-bit 2:1 gatestack mux (outputs o = sel ? b : a, bitwise).
- Accepts masked-merge requests over a valid/ready handshake:
  - base word
  - new data word
  - coarse enable vector
- Expands the enables to a per-bit select mask and buffers up to two requests in a registered 2-entry FIFO.
- Presents registered a/b/sel operands to the mux with a valid/yumi handshake, so the mux input is never driven from a combinational upstream path.

Parameters:
- width_p, 32, data/mask width in bits
- gran_p, 8, data bits controlled by one enable bit; width_p % gran_p == 0 required (elaboration-time assertion)
- en_width_lp, width_p/gran_p, derived local; not overridable

Ports:
- clk_i  input  1  clock, all state updates on rising edge
- reset_n_i  input  1  asynchronous active-low reset
- v_i  input  1  upstream request valid
- ready_o  output  1  feeder can accept a request this cycle
- base_i  input  width_p  word selected where enable=0 (mux a side)
- data_i  input  width_p  word selected where enable=1 (mux b side)
- en_i  input  en_width_lp  coarse enables, bit k covers data bits [k*gran_p +: gran_p]
- v_o  output  1  operands valid toward mux
- a_o  output  width_p  registered base word (mux i0)
- b_o  output  width_p  registered data word (mux i1)
- sel_o  output  width_p  registered expanded bit mask (mux i2)
- yumi_i  input  1  downstream consumed current operands this cycle
- count_o  output  2  FIFO occupancy, 0..2

Behaviour:
- Reset (reset_n_i low, asynchronous assert; deassertion synchronised externally):
  - both entries cleared to 0; read/write pointers and count reset to 0
  - v_o=0, a_o=b_o=sel_o=0, count_o=0, ready_o=1 while reset is low and after
  - reset mid-operation discards all stored requests; no partial output
- Storage and status:
  - Storage: 2 entries, each {base, data, expanded mask}, 1-bit write pointer wp, 1-bit read pointer rp, 2-bit count.
  - ready_o = (count != 2); purely a function of registered state, no combinational path from yumi_i.
  - v_o = (count != 0).
  - a_o/b_o/sel_o are the entry at rp, read directly from flops.
- Enqueue/dequeue:
  - enq = v_i & ready_o: entry[wp] <= {base_i, data_i, expand(en_i)}; wp toggles.
  - deq = yumi_i & v_o: rp toggles. yumi_i while v_o=0 is a protocol error: assertion fires, state unchanged.
  - count next = count + enq - deq. Simultaneous enq and deq at count=1 keeps count=1 and is legal.
  - At count=2: ready_o=0, so no enqueue that cycle even if yumi_i=1 (no same-cycle bypass); ready_o rises the following cycle.
  - At count=0: an enqueued request appears on v_o/a_o/b_o/sel_o the next cycle (latency 1). No flow-through.
  - Pointer wrap is natural 1-bit toggle; ordering is strict FIFO.
  - Output data changes only on deq or on enq into an empty FIFO. Held stable while v_o=1 and yumi_i=0.
- Mask expansion: sel bit j = en_i[j / gran_p]. With gran_p=1 it is an identity copy.
- Composition: the combined feeder + mux result is o[j] = sel_o[j] ? b_o[j] : a_o[j].

Decomposition:
- No shared package needed; en_width_lp is a local derived parameter.
- One natural combinational sub-module: bsg_expand_bitmask (parameters width_p, gran_p; in en_width_lp, out width_p). It is reusable for byte-enable writes elsewhere.
- FIFO control (pointers/count) stays inline; it is too small to justify a separate module.

Test Plan:
- Reset/idle:
  - Assert reset_n_i=0 mid-stream with count=2 → same cycle v_o=0, count_o=0, a_o=b_o=sel_o=0, ready_o=1.
  - After release, the first enqueue appears after 1 cycle.
- Byte-enable expansion (gran_p=8):
  - Inputs: base_i=32'h11223344, data_i=32'hAABBCCDD, en_i=4'b0101.
  - Next cycle: v_o=1, sel_o=32'h00FF00FF; mux result 32'h11BB33DD.
- Full/backpressure:
  - Enqueue 3 back-to-back requests with yumi_i=0 → ready_o=0 after the 2nd.
  - 3rd is not accepted (v_i held); count_o=2.
  - Outputs stay on request 1 until yumi_i.
- Full with yumi:
  - At count=2 pulse yumi_i=1 with v_i=1 → that cycle no enqueue; next cycle count_o=1, ready_o=1, outputs show request 2.
  - Held request 3 is accepted the following cycle.
- Streaming:
  - v_i=1 and yumi_i=1 every cycle with data_i = incrementing 0,1,2,… → count_o stays 1.
  - One result per cycle, in order, pointers wrap with no loss or duplication over 64 requests.
- Protocol error:
  - yumi_i=1 with v_o=0 → assertion reported; count_o remains 0, no pointer movement.
